// File: rtl/align_pkg.sv
// Shared types and defaults for the align_stream block.
// The ALIGN_PAD_EN macro adds the PAD state to the FSM encoding.
package align_pkg;

  localparam int DEF_NUM_INPUTS             = 8;
  localparam int DEF_DATA_WIDTH             = 8;
  localparam int DEF_LOG_MAX_ITERS          = 16;
  localparam int DEF_LOG_MAX_READS_PER_ITER = 16;
  localparam int DEF_WORD_WIDTH             = DEF_NUM_INPUTS * DEF_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
`ifdef ALIGN_PAD_EN
    ST_PAD  = 2'd2,
`endif
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/align_skid_buffer.sv
// Two-entry output skid buffer: head register drives the output directly,
// and push_ready is a register so no combinational path runs from pop_ready.
module align_skid_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_valid,
  output logic             push_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic             empty
);

  logic [WIDTH-1:0] head_reg, head_next;
  logic [WIDTH-1:0] tail_reg, tail_next;
  logic             head_valid_reg, head_valid_next;
  logic             tail_valid_reg, tail_valid_next;
  logic             ready_reg, ready_next;
  logic             pop, push;

  always_comb begin
    head_next       = head_reg;
    tail_next       = tail_reg;
    head_valid_next = head_valid_reg;
    tail_valid_next = tail_valid_reg;
    pop             = head_valid_reg && pop_ready;
    push            = push_valid && ready_reg;

    if (pop) begin
      // ready_reg is low whenever the tail is occupied, so no push can coincide here
      if (tail_valid_reg) begin
        head_next       = tail_reg;
        tail_valid_next = 1'b0;
      end else if (push) begin
        head_next = push_data;
      end else begin
        head_valid_next = 1'b0;
      end
    end else if (push) begin
      if (!head_valid_reg) begin
        head_next       = push_data;
        head_valid_next = 1'b1;
      end else begin
        tail_next       = push_data;
        tail_valid_next = 1'b1;
      end
    end
    ready_next = !tail_valid_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      head_valid_reg <= 1'b0;
      tail_valid_reg <= 1'b0;
      ready_reg      <= 1'b1;
    end else begin
      head_reg       <= head_next;
      tail_reg       <= tail_next;
      head_valid_reg <= head_valid_next;
      tail_valid_reg <= tail_valid_next;
      ready_reg      <= ready_next;
    end
  end

  assign push_ready = ready_reg;
  assign pop_data   = head_reg;
  assign pop_valid  = head_valid_reg;
  assign empty      = !head_valid_reg;

endmodule

// File: rtl/align_stream.sv
// Stream aligner: per iteration consume N reads, forward the leading keep words.
// Optional ALIGN_PAD_EN appends num_pad_per_iter zero words after each iteration.
module align_stream
  import align_pkg::*;
#(
  parameter int NUM_INPUTS             = DEF_NUM_INPUTS,
  parameter int DATA_WIDTH             = DEF_DATA_WIDTH,
  parameter int LOG_MAX_ITERS          = DEF_LOG_MAX_ITERS,
  parameter int LOG_MAX_READS_PER_ITER = DEF_LOG_MAX_READS_PER_ITER
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                configure,
  input  logic [LOG_MAX_ITERS-1:0]            num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]   num_reads_per_iter,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]   num_keep_per_iter,
`ifdef ALIGN_PAD_EN
  input  logic [LOG_MAX_READS_PER_ITER-1:0]   num_pad_per_iter,
`endif
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]    data_in,
  input  logic                                valid_in,
  output logic                                avail_out,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0]    data_out,
  output logic                                valid_out,
  input  logic                                avail_in,
  output logic                                busy,
  output logic                                done
);

  localparam int WORD_W = NUM_INPUTS * DATA_WIDTH;
  localparam int RW     = LOG_MAX_READS_PER_ITER;
  localparam int IW     = LOG_MAX_ITERS;

  state_t          state_reg, state_next, restart_state;
  logic [IW-1:0]   iters_reg, it_cnt_reg, it_cnt_next;
  logic [RW-1:0]   reads_reg, keep_reg, r_cnt_reg, r_cnt_next;
  logic            done_reg, done_next;
  logic            run_empty, iter_end, in_fire, r_last, it_last;
  logic            skid_ready, skid_empty, push_valid;
  logic [WORD_W-1:0] push_data;
`ifdef ALIGN_PAD_EN
  logic [RW-1:0]   pad_reg, p_cnt_reg, p_cnt_next;
  logic            p_last;
  state_t          first_state;
`endif

  assign avail_out = (state_reg == ST_READ) && skid_ready;
  assign in_fire   = valid_in && avail_out;
  assign r_last    = (r_cnt_reg == reads_reg - RW'(1));
  assign it_last   = (it_cnt_reg == iters_reg - IW'(1));

`ifdef ALIGN_PAD_EN
  assign p_last        = (p_cnt_reg == pad_reg - RW'(1));
  assign run_empty     = (num_reads_per_iter == '0) && (num_pad_per_iter == '0);
  assign first_state   = (num_reads_per_iter == '0) ? ST_PAD : ST_READ;
  assign restart_state = (reads_reg == '0) ? ST_PAD : ST_READ;
  assign push_valid    = (in_fire && (r_cnt_reg < keep_reg)) || (state_reg == ST_PAD);
  assign push_data     = (state_reg == ST_PAD) ? '0 : data_in;
`else
  assign run_empty     = (num_reads_per_iter == '0);
  assign restart_state = ST_READ;
  assign push_valid    = in_fire && (r_cnt_reg < keep_reg);
  assign push_data     = data_in;
`endif

  always_comb begin
    state_next  = state_reg;
    r_cnt_next  = r_cnt_reg;
    it_cnt_next = it_cnt_reg;
    done_next   = 1'b0;
    iter_end    = 1'b0;
`ifdef ALIGN_PAD_EN
    p_cnt_next  = p_cnt_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (configure) begin
          if ((num_iters == '0) || run_empty) begin
            done_next = 1'b1;
          end else begin
`ifdef ALIGN_PAD_EN
            state_next = first_state;
`else
            state_next = ST_READ;
`endif
          end
        end
      end
      ST_READ: begin
        if (in_fire) begin
          if (r_last) begin
            r_cnt_next = '0;
`ifdef ALIGN_PAD_EN
            if (pad_reg != '0) state_next = ST_PAD;
            else               iter_end   = 1'b1;
`else
            iter_end = 1'b1;
`endif
          end else begin
            r_cnt_next = r_cnt_reg + RW'(1);
          end
        end
      end
`ifdef ALIGN_PAD_EN
      ST_PAD: begin
        if (skid_ready) begin
          if (p_last) begin
            p_cnt_next = '0;
            iter_end   = 1'b1;
          end else begin
            p_cnt_next = p_cnt_reg + RW'(1);
          end
        end
      end
`endif
      ST_FIN: begin
        if (skid_empty) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (iter_end) begin
      if (it_last) begin
        it_cnt_next = '0;
        state_next  = ST_FIN;
      end else begin
        it_cnt_next = it_cnt_reg + IW'(1);
        state_next  = restart_state;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      iters_reg  <= '0;
      reads_reg  <= '0;
      keep_reg   <= '0;
      r_cnt_reg  <= '0;
      it_cnt_reg <= '0;
      done_reg   <= 1'b0;
`ifdef ALIGN_PAD_EN
      pad_reg    <= '0;
      p_cnt_reg  <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      r_cnt_reg  <= r_cnt_next;
      it_cnt_reg <= it_cnt_next;
      done_reg   <= done_next;
`ifdef ALIGN_PAD_EN
      p_cnt_reg  <= p_cnt_next;
`endif
      if ((state_reg == ST_IDLE) && configure) begin
        iters_reg <= num_iters;
        reads_reg <= num_reads_per_iter;
        // keep can never exceed the number of reads in an iteration
        keep_reg  <= (num_keep_per_iter > num_reads_per_iter) ? num_reads_per_iter
                                                              : num_keep_per_iter;
`ifdef ALIGN_PAD_EN
        pad_reg   <= num_pad_per_iter;
`endif
      end
    end
  end

  align_skid_buffer #(.WIDTH(WORD_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_data  (push_data),
    .push_valid (push_valid),
    .push_ready (skid_ready),
    .pop_data   (data_out),
    .pop_valid  (valid_out),
    .pop_ready  (avail_in),
    .empty      (skid_empty)
  );

  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;

endmodule

// File: tb/tb_align_stream.sv
// Directed bench for align_stream; the PAD scenario is built when ALIGN_PAD_EN is defined.
module tb_align_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        configure = 1'b0;
  logic [15:0] num_iters = '0;
  logic [15:0] num_reads_per_iter = '0;
  logic [15:0] num_keep_per_iter = '0;
`ifdef ALIGN_PAD_EN
  logic [15:0] num_pad_per_iter = '0;
`endif
  logic [63:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        avail_out;
  logic [63:0] data_out;
  logic        valid_out;
  logic        avail_in = 1'b1;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          out_cnt = 0;
  logic        rand_mode = 1'b0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  align_stream dut (
    .clk                (clk),
    .rst                (rst),
    .configure          (configure),
    .num_iters          (num_iters),
    .num_reads_per_iter (num_reads_per_iter),
    .num_keep_per_iter  (num_keep_per_iter),
`ifdef ALIGN_PAD_EN
    .num_pad_per_iter   (num_pad_per_iter),
`endif
    .data_in            (data_in),
    .valid_in           (valid_in),
    .avail_out          (avail_out),
    .data_out           (data_out),
    .valid_out          (valid_out),
    .avail_in           (avail_in),
    .busy               (busy),
    .done               (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word(input int v);
    word = 64'(v) * 64'h0101010101010101 + 64'h0706050403020100;
  endfunction

  // Output monitor: scoreboard, hold-while-stalled and done counting, all on the falling edge
  initial begin
    logic        stall_prev;
    logic [63:0] data_prev;
    logic [63:0] exp;
    stall_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", 64'(valid_out), 64'd1);
          check("hold_data", data_out, data_prev);
        end
        if (done) done_cnt++;
        if (valid_out && avail_in) begin
          if (exp_q.size() == 0) begin
            check("extra_word", 64'd1, 64'd0);
          end else begin
            exp = exp_q.pop_front();
            check("data_out", data_out, exp);
          end
          $display("out %0d data=%h", out_cnt, data_out);
          out_cnt++;
        end
        stall_prev = valid_out && !avail_in;
        data_prev  = data_out;
      end
    end
  end

  // Random downstream back-pressure, active only while rand_mode is set
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) avail_in = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic do_config(input int iters, input int reads, input int keep);
    num_iters          = 16'(iters);
    num_reads_per_iter = 16'(reads);
    num_keep_per_iter  = 16'(keep);
    configure          = 1'b1;
    @(posedge clk);
    #1;
    configure = 1'b0;
  endtask

  task automatic drive_stream(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      logic acc;
      int   waited;
      valid_in = 1'b1;
      data_in  = word(base + i);
      waited   = 0;
      do begin
        @(negedge clk);
        acc = avail_out;
        @(posedge clk);
        #1;
        waited++;
      end while (!acc && waited < 200);
      if (!acc) check("in_timeout", 64'd0, 64'd1);
    end
    valid_in = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int done0);
    for (int i = 0; i < 2000 && done_cnt == done0; i++) @(posedge clk);
    #1;
    if (done_cnt == done0) check({tag, "_done_timeout"}, 64'd0, 64'd1);
    rand_mode = 1'b0;
    @(posedge clk);
    #2;
    avail_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_once"}, 64'(done_cnt - done0), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_words_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int done0;
    int t2_idx[6];

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_data_out", data_out, 64'd0);
    check("rst_avail_out", 64'(avail_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;

    // 1) full pass-through, two iterations of four
    done0 = done_cnt;
    for (int i = 0; i < 8; i++) exp_q.push_back(word(i));
    do_config(2, 4, 4);
    @(negedge clk);
    check("t1_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    drive_stream(8, 0);
    finish_run("t1", done0);

    // 2) keep 2 of 5 over three iterations
    done0 = done_cnt;
    t2_idx = '{0, 1, 5, 6, 10, 11};
    foreach (t2_idx[i]) exp_q.push_back(word(t2_idx[i]));
    do_config(3, 5, 2);
    drive_stream(15, 0);
    finish_run("t2", done0);

    // 3a) keep larger than reads is clamped
    done0 = done_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back(word(20 + i));
    do_config(1, 3, 7);
    drive_stream(3, 20);
    finish_run("t3", done0);

    // 3b) zero iterations: done one cycle after configure, no traffic
    do_config(0, 4, 4);
    @(negedge clk);
    check("t3_zero_done", 64'(done), 64'd1);
    check("t3_zero_busy", 64'(busy), 64'd0);
    check("t3_zero_avail", 64'(avail_out), 64'd0);
    @(negedge clk);
    check("t3_zero_done_drop", 64'(done), 64'd0);
    check("t3_zero_valid", 64'(valid_out), 64'd0);
    @(posedge clk);
    #1;

    // 4) random downstream stalls
    done0 = done_cnt;
    for (int i = 0; i < 32; i++) exp_q.push_back(word(40 + i));
    rand_mode = 1'b1;
    do_config(4, 8, 8);
    drive_stream(32, 40);
    finish_run("t4", done0);

`ifdef ALIGN_PAD_EN
    // 5) zero padding after each iteration
    done0 = done_cnt;
    exp_q.push_back(word(80));
    exp_q.push_back(word(81));
    repeat (3) exp_q.push_back(64'd0);
    exp_q.push_back(word(82));
    exp_q.push_back(word(83));
    repeat (3) exp_q.push_back(64'd0);
    num_pad_per_iter = 16'd3;
    do_config(2, 2, 2);
    drive_stream(2, 80);
    @(negedge clk);
    check("t5_pad_avail_0", 64'(avail_out), 64'd0);
    @(posedge clk);
    #1;
    drive_stream(2, 82);
    @(negedge clk);
    check("t5_pad_avail_1", 64'(avail_out), 64'd0);
    @(posedge clk);
    #1;
    finish_run("t5", done0);
    num_pad_per_iter = 16'd0;
`endif

    // 6) reset with the skid buffer full
    avail_in = 1'b0;
    do_config(1, 8, 8);
    valid_in = 1'b1;
    data_in  = word(100);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("t6_full_avail", 64'(avail_out), 64'd0);
    check("t6_full_valid", 64'(valid_out), 64'd1);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", 64'(valid_out), 64'd0);
    check("t6_rst_avail", 64'(avail_out), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    avail_in = 1'b1;
    done0 = done_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back(word(110 + i));
    do_config(1, 3, 3);
    drive_stream(3, 110);
    finish_run("t6", done0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
